// File: rtl/bufgce_ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bufgce_ce_sequencer
// Brief    : Clock-enable sequencer for a downstream BUFGCE. Synchronizes an
//            asynchronous enable request, applies a wake-up dwell before CE
//            asserts, a drain dwell before CE deasserts, and an optional
//            idle-timeout auto-gate driven by a synchronous ACTIVITY input.
// Revision : 1.0 - initial release
// ============================================================================
module bufgce_ce_sequencer #(
  parameter int   SYNC_STAGES    = 2,
  parameter int   WAKE_CYCLES    = 4,
  parameter int   DRAIN_CYCLES   = 4,
  parameter int   IDLE_TIMEOUT   = 0,
  parameter int   CNT_WIDTH      = 8,
  parameter logic IS_CE_INVERTED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_req,
  input  logic       activity,
  output logic       ce,
  output logic       en_ack,
  output logic       busy,
  output logic       idle_gated,
  output logic [1:0] state
);

  // State encoding is visible on the state port, so it is fixed here.
  localparam logic [1:0] c_ST_OFF   = 2'b00;
  localparam logic [1:0] c_ST_WAKE  = 2'b01;
  localparam logic [1:0] c_ST_ON    = 2'b10;
  localparam logic [1:0] c_ST_DRAIN = 2'b11;

  // Counter preloads; a zero dwell skips its state, so the load is unused then.
  localparam logic [CNT_WIDTH-1:0] c_WAKE_LOAD  =
    CNT_WIDTH'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] c_DRAIN_LOAD =
    CNT_WIDTH'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] c_IDLE_LAST  =
    CNT_WIDTH'((IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] c_IDLE_MAX   = CNT_WIDTH'(IDLE_TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_en_s;

  logic [1:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_idle_cnt;
  logic                   r_idle_gated;
  logic                   r_ce;
  logic                   r_en_ack;
  logic                   r_busy;

  logic [1:0]             w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [CNT_WIDTH-1:0]   w_idle_cnt_nxt;
  logic                   w_idle_gated_nxt;
  logic                   w_ce_nxt;
  logic                   w_en_ack_nxt;
  logic                   w_busy_nxt;

  assign w_en_s = r_sync[SYNC_STAGES-1];

  // Multi-flop synchronizer bringing the asynchronous request into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], en_req};
    end
  end

  // State, counters and next-state-decoded outputs update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_OFF;
      r_cnt        <= '0;
      r_idle_cnt   <= '0;
      r_idle_gated <= 1'b0;
      r_ce         <= IS_CE_INVERTED;
      r_en_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_idle_gated <= w_idle_gated_nxt;
      r_ce         <= w_ce_nxt;
      r_en_ack     <= w_en_ack_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state, dwell counter, idle counter and idle-gate flag.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idle_cnt_nxt   = '0;
    w_idle_gated_nxt = r_idle_gated;
    case (r_state)
      c_ST_OFF: begin
        if (!w_en_s) begin
          w_idle_gated_nxt = 1'b0;
        end else if (!r_idle_gated || activity) begin
          // Idle-gated wake-up needs fresh activity, not just the request.
          w_idle_gated_nxt = 1'b0;
          if (WAKE_CYCLES == 0) begin
            w_state_nxt = c_ST_ON;
          end else begin
            w_state_nxt = c_ST_WAKE;
            w_cnt_nxt   = c_WAKE_LOAD;
          end
        end
      end
      c_ST_WAKE: begin
        // Abort wins over the final dwell cycle so CE never asserts.
        if (!w_en_s) begin
          w_state_nxt = c_ST_OFF;
        end else if (r_cnt == '0) begin
          w_state_nxt = c_ST_ON;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      c_ST_ON: begin
        if (activity) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt != c_IDLE_MAX) begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt;
        end
        if (!w_en_s) begin
          w_state_nxt = (DRAIN_CYCLES == 0) ? c_ST_OFF : c_ST_DRAIN;
          w_cnt_nxt   = c_DRAIN_LOAD;
        end else if ((IDLE_TIMEOUT != 0) && !activity &&
                     (r_idle_cnt == c_IDLE_LAST)) begin
          w_state_nxt      = (DRAIN_CYCLES == 0) ? c_ST_OFF : c_ST_DRAIN;
          w_cnt_nxt        = c_DRAIN_LOAD;
          w_idle_gated_nxt = 1'b1;
        end
      end
      default: begin
        // Drain: the reason for gating decides what reclaims the clock.
        if (r_idle_gated ? activity : w_en_s) begin
          w_state_nxt      = c_ST_ON;
          w_idle_gated_nxt = 1'b0;
        end else if (r_cnt == '0) begin
          w_state_nxt = c_ST_OFF;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
    endcase
  end

  // Output decode from next state, so outputs are aligned with the state port.
  always_comb begin
    w_ce_nxt     = ((w_state_nxt == c_ST_ON) || (w_state_nxt == c_ST_DRAIN))
                   ^ IS_CE_INVERTED;
    w_en_ack_nxt = (w_state_nxt == c_ST_ON);
    w_busy_nxt   = (w_state_nxt == c_ST_WAKE) || (w_state_nxt == c_ST_DRAIN);
  end

  assign ce         = r_ce;
  assign en_ack     = r_en_ack;
  assign busy       = r_busy;
  assign idle_gated = r_idle_gated;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bufgce_ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bufgce_ce_sequencer
// Brief    : Directed self-checking bench for bufgce_ce_sequencer. Instance A
//            uses defaults, B enables an 8-cycle idle timeout, C inverts CE
//            and shares A's stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bufgce_ce_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en_a = 1'b0, act_a = 1'b0;
  logic       en_b = 1'b0, act_b = 1'b0;
  logic       ce_a, ack_a, busy_a, idle_a;
  logic       ce_b, ack_b, busy_b, idle_b;
  logic       ce_c, ack_c, busy_c, idle_c;
  logic [1:0] st_a, st_b, st_c;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  bufgce_ce_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .en_req(en_a), .activity(act_a),
    .ce(ce_a), .en_ack(ack_a), .busy(busy_a), .idle_gated(idle_a), .state(st_a)
  );

  bufgce_ce_sequencer #(.IDLE_TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en_req(en_b), .activity(act_b),
    .ce(ce_b), .en_ack(ack_b), .busy(busy_b), .idle_gated(idle_b), .state(st_b)
  );

  bufgce_ce_sequencer #(.IS_CE_INVERTED(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en_req(en_a), .activity(act_a),
    .ce(ce_c), .en_ack(ack_c), .busy(busy_c), .idle_gated(idle_c), .state(st_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    n_tests += 8;
    if (st_a !== 2'b00) begin n_fail++; $display("FAIL reset.state_a got %b want 00", st_a); end
    if (ce_a !== 1'b0) begin n_fail++; $display("FAIL reset.ce_a got %b want 0", ce_a); end
    if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset.ack_a got %b want 0", ack_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset.busy_a got %b want 0", busy_a); end
    if (idle_b !== 1'b0) begin n_fail++; $display("FAIL reset.idle_b got %b want 0", idle_b); end
    if (ce_b !== 1'b0) begin n_fail++; $display("FAIL reset.ce_b got %b want 0", ce_b); end
    if (ce_c !== 1'b1) begin n_fail++; $display("FAIL reset.ce_c got %b want 1", ce_c); end
    if (st_c !== 2'b00) begin n_fail++; $display("FAIL reset.state_c got %b want 00", st_c); end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  // Full request/release with defaults; C must mirror A with inverted CE.
  task automatic test_on_off();
    logic [1:0] es;
    logic       ece, eack, ebusy;
    en_a = 1'b1;
    for (int k = 0; k < 28; k++) begin
      if (k == 20) en_a = 1'b0;
      tick();
      es    = (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : (k < 22) ? 2'b10 : (k < 26) ? 2'b11 : 2'b00;
      ece   = (k >= 6) && (k < 26);
      eack  = (k >= 6) && (k < 22);
      ebusy = ((k >= 2) && (k < 6)) || ((k >= 22) && (k < 26));
      n_tests += 6;
      if (st_a !== es) begin n_fail++; $display("FAIL on_off.state edge %0d got %b want %b", k, st_a, es); end
      if (ce_a !== ece) begin n_fail++; $display("FAIL on_off.ce edge %0d got %b want %b", k, ce_a, ece); end
      if (ack_a !== eack) begin n_fail++; $display("FAIL on_off.ack edge %0d got %b want %b", k, ack_a, eack); end
      if (busy_a !== ebusy) begin n_fail++; $display("FAIL on_off.busy edge %0d got %b want %b", k, busy_a, ebusy); end
      if (ce_c !== ~ece) begin n_fail++; $display("FAIL on_off.ce_inv edge %0d got %b want %b", k, ce_c, ~ece); end
      if (st_c !== es) begin n_fail++; $display("FAIL on_off.state_inv edge %0d got %b want %b", k, st_c, es); end
    end
    repeat (4) tick();
  endtask

  // Request dropped mid-wake; the abort lands on the last wake cycle.
  task automatic test_wake_abort();
    logic [1:0] es;
    logic       ebusy;
    en_a = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 4) en_a = 1'b0;
      tick();
      es    = (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : 2'b00;
      ebusy = (k >= 2) && (k < 6);
      n_tests += 4;
      if (st_a !== es) begin n_fail++; $display("FAIL wake_abort.state edge %0d got %b want %b", k, st_a, es); end
      if (ce_a !== 1'b0) begin n_fail++; $display("FAIL wake_abort.ce edge %0d got %b want 0", k, ce_a); end
      if (busy_a !== ebusy) begin n_fail++; $display("FAIL wake_abort.busy edge %0d got %b want %b", k, busy_a, ebusy); end
      if (ack_a !== 1'b0) begin n_fail++; $display("FAIL wake_abort.ack edge %0d got %b want 0", k, ack_a); end
    end
    repeat (4) tick();
  endtask

  // Request re-raised during drain returns to ON without a CE gap.
  task automatic test_drain_reclaim();
    logic [1:0] es;
    logic       ece, eack;
    en_a = 1'b1;
    for (int k = 0; k < 23; k++) begin
      if (k == 12) en_a = 1'b0;
      if (k == 15) en_a = 1'b1;
      tick();
      es   = (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : (k < 14) ? 2'b10 : (k < 17) ? 2'b11 : 2'b10;
      ece  = (k >= 6);
      eack = (k >= 6) && !((k >= 14) && (k < 17));
      n_tests += 3;
      if (st_a !== es) begin n_fail++; $display("FAIL drain_reclaim.state edge %0d got %b want %b", k, st_a, es); end
      if (ce_a !== ece) begin n_fail++; $display("FAIL drain_reclaim.ce edge %0d got %b want %b", k, ce_a, ece); end
      if (ack_a !== eack) begin n_fail++; $display("FAIL drain_reclaim.ack edge %0d got %b want %b", k, ack_a, eack); end
    end
    en_a = 1'b0;
    repeat (12) tick();
    n_tests++;
    if (st_a !== 2'b00) begin n_fail++; $display("FAIL drain_reclaim.final_state got %b want 00", st_a); end
  endtask

  // Idle timeout gates after 8 quiet cycles; an activity pulse wakes it.
  task automatic test_idle_timeout();
    logic [1:0] es;
    logic       ece, eidle, ebusy;
    en_b  = 1'b1;
    act_b = 1'b0;
    for (int k = 0; k < 28; k++) begin
      act_b = (k == 22);
      tick();
      es    = (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : (k < 14) ? 2'b10 : (k < 18) ? 2'b11 :
              (k < 22) ? 2'b00 : (k < 26) ? 2'b01 : 2'b10;
      ece   = ((k >= 6) && (k < 18)) || (k >= 26);
      eidle = (k >= 14) && (k < 22);
      ebusy = ((k >= 2) && (k < 6)) || ((k >= 14) && (k < 18)) || ((k >= 22) && (k < 26));
      n_tests += 4;
      if (st_b !== es) begin n_fail++; $display("FAIL idle.state edge %0d got %b want %b", k, st_b, es); end
      if (ce_b !== ece) begin n_fail++; $display("FAIL idle.ce edge %0d got %b want %b", k, ce_b, ece); end
      if (idle_b !== eidle) begin n_fail++; $display("FAIL idle.gated edge %0d got %b want %b", k, idle_b, eidle); end
      if (busy_b !== ebusy) begin n_fail++; $display("FAIL idle.busy edge %0d got %b want %b", k, busy_b, ebusy); end
    end
    act_b = 1'b0;
    en_b  = 1'b0;
    repeat (12) tick();
    n_tests += 2;
    if (st_b !== 2'b00) begin n_fail++; $display("FAIL idle.final_state got %b want 00", st_b); end
    if (idle_b !== 1'b0) begin n_fail++; $display("FAIL idle.final_gated got %b want 0", idle_b); end
  endtask

  // Reset pulled mid-ON gates immediately without a clock edge, then restart.
  task automatic test_async_reset();
    logic [1:0] es;
    logic       ece;
    en_a = 1'b1;
    repeat (8) tick();
    n_tests++;
    if (st_a !== 2'b10) begin n_fail++; $display("FAIL async_rst.pre_state got %b want 10", st_a); end
    #2 rst_n = 1'b0;
    #1;
    n_tests += 6;
    if (ce_a !== 1'b0) begin n_fail++; $display("FAIL async_rst.ce got %b want 0", ce_a); end
    if (st_a !== 2'b00) begin n_fail++; $display("FAIL async_rst.state got %b want 00", st_a); end
    if (ack_a !== 1'b0) begin n_fail++; $display("FAIL async_rst.ack got %b want 0", ack_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async_rst.busy got %b want 0", busy_a); end
    if (ce_c !== 1'b1) begin n_fail++; $display("FAIL async_rst.ce_inv got %b want 1", ce_c); end
    if (ack_c !== 1'b0) begin n_fail++; $display("FAIL async_rst.ack_inv got %b want 0", ack_c); end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      es  = (k < 2) ? 2'b00 : (k < 6) ? 2'b01 : 2'b10;
      ece = (k >= 6);
      n_tests += 2;
      if (st_a !== es) begin n_fail++; $display("FAIL async_rst.restart_state edge %0d got %b want %b", k, st_a, es); end
      if (ce_a !== ece) begin n_fail++; $display("FAIL async_rst.restart_ce edge %0d got %b want %b", k, ce_a, ece); end
    end
    en_a = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_wake_abort();
    test_drain_reclaim();
    test_idle_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
